// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// in 32 cycles (one bit per cycle) and MTHI/MTLO in one.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDCtrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_cnt;
  logic [1:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_in1;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_sgn;
  logic               w_md_op;
  logic               w_last;
  logic               w_busy;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_q_fin;
  logic [WIDTH-1:0]   w_r_fin;

  // Ops 0 and 2 are the signed ones; 32'h80000000 negates to itself, read as unsigned 2^31.
  assign w_md_op = ~MDCtrl[2];
  assign w_sgn   = ~MDCtrl[0];
  assign w_mag_a = (w_sgn && in1[WIDTH-1]) ? -in1 : in1;
  assign w_mag_b = (w_sgn && in2[WIDTH-1]) ? -in2 : in2;
  assign w_last  = (r_cnt == 6'd31);

  // Shift-add: multiplier sits in the low half of the accumulator and shifts out LSB first.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;

  // Restoring division: the 33-bit trial remainder is compared against the divisor.
  // A successful subtract always leaves a value below the divisor, so WIDTH bits suffice.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_b});
  assign w_diff    = w_trial[WIDTH-1:0] - r_b;
  assign w_rem_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Zero divisor bypasses the sign fix so HI returns the raw dividend.
  assign w_q_fin = (r_b == '0) ? {WIDTH{1'b1}} : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
  assign w_r_fin = (r_b == '0) ? r_in1 : (r_neg_r ? -w_rem_nxt : w_rem_nxt);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && w_md_op) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_in1   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          case (MDCtrl)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              r_op    <= MDCtrl[1:0];
              r_cnt   <= '0;
              r_neg_q <= w_sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
              r_neg_r <= w_sgn & in1[WIDTH-1];
              r_a     <= w_mag_a;
              r_b     <= w_mag_b;
              r_in1   <= in1;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
              r_rem   <= '0;
              r_quo   <= w_mag_a;
            end
            3'd4:    r_hi <= in1;
            3'd5:    r_lo <= in1;
            default: ;
          endcase
        end
      end else begin
        r_cnt <= r_cnt + 6'd1;
        if (!r_op[1]) begin
          r_acc <= w_acc_nxt;
        end else begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
        end
        if (w_last) begin
          r_done <= 1'b1;
          if (!r_op[1]) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else begin
            r_hi <= w_r_fin;
            r_lo <= w_q_fin;
          end
        end
      end
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule
